voice_frame_sched: RTL and testbench

- Frame scheduler that sits between the FFT output stage and the 1024-bin spectral remap engine (the boy-to-girl pitch-shift unit).
- Writes incoming FFT frames into a two-bank ping-pong spectrum RAM.
- Hands full banks to the read side in arrival order, and drives the remap engine's enable window.
- Muxes the RAM read address between the engine's remapped address and a linear bypass counter, according to a per-frame latched mode.

---
 rtl/voice_frame_sched.sv | 215 +++++++++++++++++++++
 tb/tb_voice_frame_sched.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_frame_sched.sv
// Frame scheduler between the FFT output stage and the spectral remap engine.
// FFT frames are written into a two-bank ping-pong spectrum RAM. Full banks
// are handed to the read side in arrival order. The read side drives the remap
// engine enable window and selects the RAM read address for each frame.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   fft_valid/last     incoming bin stream from the FFT
//   wr_en/bank/addr    RAM write side
//   mode_in            0 bypass, 1 remap, 2 mute, 3 bypass (latched per frame)
//   ifft_ready         downstream can take a new frame (sampled in IDLE only)
//   remap_enable       remap engine run window
//   remap_addr/tlast   engine read address and end-of-frame
//   rd_bank/rd_addr    RAM read side
//   mute               mute-mode frame in RUN
//   busy               read FSM not idle
//   drop_cnt           saturating count of dropped frames
//   err_timeout        sticky: the engine never signalled end-of-frame
module voice_frame_sched #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned BYP_LAT  = 2,
  parameter int unsigned DRAIN_TO = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fft_valid,
  input  logic              fft_last,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic [1:0]        mode_in,
  input  logic              ifft_ready,
  output logic              remap_enable,
  input  logic [ADDR_W-1:0] remap_addr,
  input  logic              remap_tlast,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              mute,
  output logic              busy,
  output logic [7:0]        drop_cnt,
  output logic              err_timeout
);

  localparam int unsigned DRAIN_MAX = (DRAIN_TO > BYP_LAT) ? DRAIN_TO : BYP_LAT;
  localparam int unsigned DCNT_W    = $clog2(DRAIN_MAX + 1);
  localparam logic [ADDR_W-1:0] RUN_LAST = '1;
  localparam logic [1:0] MODE_REMAP = 2'd1;
  localparam logic [1:0] MODE_MUTE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          full_q, full_d;
  logic                order_q, order_d;
  logic                rd_bank_q, rd_bank_d;
  logic [1:0]          mode_q, mode_d;
  logic [ADDR_W-1:0]   run_cnt_q, run_cnt_d;
  logic [DCNT_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic                tlast_seen_q, tlast_seen_d;
  logic                remap_enable_q, remap_enable_d;
  logic                mute_q, mute_d;
  logic                busy_q, busy_d;
  logic                err_timeout_q, err_timeout_d;
  logic                wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic                dropping_q, dropping_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;

  logic                rel_c;
  logic [1:0]          full_rel;

  // Read FSM, then the write side which sees the banks after any release
  always_comb begin
    state_d        = state_q;
    full_d         = full_q;
    order_d        = order_q;
    rd_bank_d      = rd_bank_q;
    mode_d         = mode_q;
    run_cnt_d      = run_cnt_q;
    drain_cnt_d    = drain_cnt_q;
    tlast_seen_d   = tlast_seen_q;
    remap_enable_d = remap_enable_q;
    mute_d         = mute_q;
    err_timeout_d  = err_timeout_q;
    wr_bank_d      = wr_bank_q;
    wr_addr_d      = wr_addr_q;
    dropping_d     = dropping_q;
    drop_cnt_d     = drop_cnt_q;
    rel_c          = 1'b0;
    full_rel       = full_q;

    unique case (state_q)
      S_IDLE: begin
        if ((|full_q) && ifft_ready) begin
          // Oldest full bank first; order bit names it
          rd_bank_d      = full_q[order_q] ? order_q : ~order_q;
          mode_d         = mode_in;
          run_cnt_d      = '0;
          tlast_seen_d   = 1'b0;
          remap_enable_d = (mode_in == MODE_REMAP);
          mute_d         = (mode_in == MODE_MUTE);
          state_d        = S_RUN;
        end
      end
      S_RUN: begin
        run_cnt_d = run_cnt_q + 1'b1;
        // An early end-of-frame from the engine still counts in DRAIN
        if (remap_tlast) tlast_seen_d = 1'b1;
        if (run_cnt_q == RUN_LAST) begin
          state_d        = S_DRAIN;
          drain_cnt_d    = '0;
          remap_enable_d = 1'b0;
          mute_d         = 1'b0;
        end
      end
      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (mode_q == MODE_REMAP) begin
          if (tlast_seen_q || remap_tlast) begin
            rel_c = 1'b1;
          end else if (drain_cnt_q == DCNT_W'(DRAIN_TO - 1)) begin
            rel_c         = 1'b1;
            err_timeout_d = 1'b1;
          end
        end else if (drain_cnt_q == DCNT_W'(BYP_LAT - 1)) begin
          rel_c = 1'b1;
        end
        if (rel_c) begin
          full_rel[rd_bank_q] = 1'b0;
          order_d             = ~rd_bank_q;
          state_d             = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    full_d = full_rel;

    if (fft_valid && !dropping_q) wr_addr_d = wr_addr_q + 1'b1;

    if (fft_valid && fft_last) begin
      wr_addr_d = '0;
      if (dropping_q) begin
        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end else begin
        full_d[wr_bank_q] = 1'b1;
      end
      // Next frame goes to the other bank if free, else it is dropped
      if (!full_rel[~wr_bank_q]) begin
        wr_bank_d  = ~wr_bank_q;
        dropping_d = 1'b0;
      end else if (dropping_q && !full_rel[wr_bank_q]) begin
        dropping_d = 1'b0;
      end else begin
        dropping_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      full_q         <= '0;
      order_q        <= 1'b0;
      rd_bank_q      <= 1'b0;
      mode_q         <= '0;
      run_cnt_q      <= '0;
      drain_cnt_q    <= '0;
      tlast_seen_q   <= 1'b0;
      remap_enable_q <= 1'b0;
      mute_q         <= 1'b0;
      busy_q         <= 1'b0;
      err_timeout_q  <= 1'b0;
      wr_bank_q      <= 1'b0;
      wr_addr_q      <= '0;
      dropping_q     <= 1'b0;
      drop_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      full_q         <= full_d;
      order_q        <= order_d;
      rd_bank_q      <= rd_bank_d;
      mode_q         <= mode_d;
      run_cnt_q      <= run_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      tlast_seen_q   <= tlast_seen_d;
      remap_enable_q <= remap_enable_d;
      mute_q         <= mute_d;
      busy_q         <= busy_d;
      err_timeout_q  <= err_timeout_d;
      wr_bank_q      <= wr_bank_d;
      wr_addr_q      <= wr_addr_d;
      dropping_q     <= dropping_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  assign wr_en        = fft_valid & ~dropping_q;
  assign wr_bank      = wr_bank_q;
  assign wr_addr      = wr_addr_q;
  assign remap_enable = remap_enable_q;
  assign rd_bank      = rd_bank_q;
  // Engine address in remap mode, linear sweep otherwise
  assign rd_addr      = (mode_q == MODE_REMAP) ? remap_addr : run_cnt_q;
  assign mute         = mute_q;
  assign busy         = busy_q;
  assign drop_cnt     = drop_cnt_q;
  assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_voice_frame_sched.sv
// Directed bench for voice_frame_sched: inputs change on the falling edge,
// outputs are observed 1 time unit later.
module tb_voice_frame_sched;

  localparam int unsigned ADDR_W = 10;
  localparam int NBINS = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              fft_valid;
  logic              fft_last;
  logic              wr_en;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        mode_in;
  logic              ifft_ready;
  logic              remap_enable;
  logic [ADDR_W-1:0] remap_addr;
  logic              remap_tlast;
  logic              rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic              mute;
  logic              busy;
  logic [7:0]        drop_cnt;
  logic              err_timeout;

  int n_checks = 0;
  int n_errors = 0;

  voice_frame_sched #(.ADDR_W(ADDR_W), .BYP_LAT(2), .DRAIN_TO(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .fft_valid    (fft_valid),
    .fft_last     (fft_last),
    .wr_en        (wr_en),
    .wr_bank      (wr_bank),
    .wr_addr      (wr_addr),
    .mode_in      (mode_in),
    .ifft_ready   (ifft_ready),
    .remap_enable (remap_enable),
    .remap_addr   (remap_addr),
    .remap_tlast  (remap_tlast),
    .rd_bank      (rd_bank),
    .rd_addr      (rd_addr),
    .mute         (mute),
    .busy         (busy),
    .drop_cnt     (drop_cnt),
    .err_timeout  (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    fft_valid = 1'b0;
    fft_last  = 1'b0;
    #1;
  endtask

  // Stream one frame of nbins; exp_wr says whether it should be written
  task automatic send_frame(input int nbins, input logic exp_wr, input string tag);
    int bad;
    logic [ADDR_W-1:0] ea;
    bad = 0;
    for (int i = 0; i < nbins; i++) begin
      @(negedge clk);
      fft_valid = 1'b1;
      fft_last  = (i == nbins - 1);
      #1;
      ea = exp_wr ? ADDR_W'(i) : '0;
      if (wr_en !== exp_wr) bad++;
      if (wr_addr !== ea) bad++;
    end
    chk({tag, "_write"}, 32'(bad), 32'd0);
  endtask

  // Request one frame from the reader and act as the remap engine while it runs
  task automatic serve(input logic [1:0] mode, input int tlast_idx,
                       output int n_busy, output int n_en, output int n_bad,
                       output logic bank);
    int idx;
    logic [ADDR_W-1:0] exp_addr;
    n_busy = 0;
    n_en   = 0;
    n_bad  = 0;
    bank   = 1'bx;
    mode_in    = mode;
    ifft_ready = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (busy !== 1'b1 && n_busy > 0) break;
      if (busy === 1'b1) begin
        idx = n_busy;
        ifft_ready = 1'b0;
        mode_in    = ~mode;
        if (idx == 0) bank = rd_bank;
        remap_addr  = ADDR_W'($urandom);
        remap_tlast = (idx == tlast_idx);
        #1;
        if (idx < NBINS) begin
          exp_addr = (mode == 2'd1) ? remap_addr : ADDR_W'(idx);
          if (rd_addr !== exp_addr) n_bad++;
          if (mute !== (mode == 2'd2)) n_bad++;
        end else if (mute !== 1'b0) begin
          n_bad++;
        end
        if (remap_enable !== (mode == 2'd1 && idx < NBINS)) n_bad++;
        if (remap_enable === 1'b1) n_en++;
        n_busy++;
      end else begin
        remap_tlast = 1'b0;
      end
    end
    remap_tlast = 1'b0;
    ifft_ready  = 1'b0;
    #1;
  endtask

  initial begin
    int nb, ne, nbad, bad;
    logic bk;

    rst         = 1'b1;
    fft_valid   = 1'b0;
    fft_last    = 1'b0;
    mode_in     = 2'd0;
    ifft_ready  = 1'b0;
    remap_addr  = '0;
    remap_tlast = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wr_en",        32'(wr_en), 32'd0);
    chk("rst_wr_bank",      32'(wr_bank), 32'd0);
    chk("rst_wr_addr",      32'(wr_addr), 32'd0);
    chk("rst_remap_enable", 32'(remap_enable), 32'd0);
    chk("rst_rd_bank",      32'(rd_bank), 32'd0);
    chk("rst_rd_addr",      32'(rd_addr), 32'd0);
    chk("rst_mute",         32'(mute), 32'd0);
    chk("rst_busy",         32'(busy), 32'd0);
    chk("rst_drop_cnt",     32'(drop_cnt), 32'd0);
    chk("rst_err_timeout",  32'(err_timeout), 32'd0);
    rst = 1'b0;

    // Remap frame into bank 0; tlast arrives in the first DRAIN cycle
    send_frame(NBINS, 1'b1, "t1_frame");
    idle();
    chk("t1_wr_bank_toggled", 32'(wr_bank), 32'd1);
    chk("t1_wr_addr_zero",    32'(wr_addr), 32'd0);
    chk("t1_not_busy",        32'(busy), 32'd0);
    serve(2'd1, NBINS, nb, ne, nbad, bk);
    chk("t1_rd_bank",  32'(bk), 32'd0);
    chk("t1_en_cycles", 32'(ne), 32'd1024);
    chk("t1_busy_len", 32'(nb), 32'd1025);
    chk("t1_rd_path",  32'(nbad), 32'd0);

    // Bypass frame into bank 1
    send_frame(NBINS, 1'b1, "t2_frame");
    idle();
    chk("t2_wr_bank", 32'(wr_bank), 32'd0);
    serve(2'd0, -1, nb, ne, nbad, bk);
    chk("t2_rd_bank",  32'(bk), 32'd1);
    chk("t2_en_cycles", 32'(ne), 32'd0);
    chk("t2_busy_len", 32'(nb), 32'd1026);
    chk("t2_rd_linear", 32'(nbad), 32'd0);
    chk("t2_no_timeout", 32'(err_timeout), 32'd0);

    // Three back-to-back frames with the reader stalled: third is dropped
    send_frame(NBINS, 1'b1, "t3_f1");
    send_frame(NBINS, 1'b1, "t3_f2");
    send_frame(NBINS, 1'b0, "t3_f3_dropped");
    idle();
    chk("t3_drop_cnt", 32'(drop_cnt), 32'd1);
    chk("t3_wr_bank",  32'(wr_bank), 32'd1);
    serve(2'd1, 1000, nb, ne, nbad, bk);
    chk("t3_first_bank",  32'(bk), 32'd0);
    chk("t3_first_len",   32'(nb), 32'd1025);
    chk("t3_first_path",  32'(nbad), 32'd0);
    serve(2'd2, -1, nb, ne, nbad, bk);
    chk("t3_second_bank", 32'(bk), 32'd1);
    chk("t3_second_len",  32'(nb), 32'd1026);
    chk("t3_mute_path",   32'(nbad), 32'd0);

    // Pending drop completes, then a remap frame whose engine never ends
    send_frame(NBINS, 1'b0, "t4_dropped");
    idle();
    chk("t4_drop_cnt", 32'(drop_cnt), 32'd2);
    chk("t4_wr_bank",  32'(wr_bank), 32'd0);
    send_frame(NBINS, 1'b1, "t4_frame");
    idle();
    serve(2'd1, -1, nb, ne, nbad, bk);
    chk("t4_rd_bank",   32'(bk), 32'd0);
    chk("t4_busy_len",  32'(nb), 32'd1040);
    chk("t4_en_cycles", 32'(ne), 32'd1024);
    chk("t4_err_timeout", 32'(err_timeout), 32'd1);

    // Bank 1 served, bank 0 filled; then bank 1 closes as bank 0 is released
    send_frame(NBINS, 1'b1, "t5_setup_b1");
    idle();
    serve(2'd0, -1, nb, ne, nbad, bk);
    chk("t5_setup_bank", 32'(bk), 32'd1);
    send_frame(NBINS, 1'b1, "t5_setup_b0");
    idle();
    chk("t5_setup_wr_bank", 32'(wr_bank), 32'd1);
    @(negedge clk);
    ifft_ready = 1'b1;
    mode_in    = 2'd0;
    bad = 0;
    for (int c = 1; c <= 1026; c++) begin
      @(negedge clk);
      ifft_ready = 1'b0;
      fft_valid  = (c >= 3);
      fft_last   = (c == 1026);
      #1;
      if (busy !== 1'b1) bad++;
      if (c >= 3 && wr_en !== 1'b1) bad++;
    end
    chk("t5_overlap", 32'(bad), 32'd0);
    idle();
    chk("t5_released",   32'(busy), 32'd0);
    chk("t5_wr_bank",    32'(wr_bank), 32'd0);
    chk("t5_no_drop",    32'(drop_cnt), 32'd2);
    chk("t5_err_sticky", 32'(err_timeout), 32'd1);

    // Reset in the middle of a remap RUN
    @(negedge clk);
    ifft_ready = 1'b1;
    mode_in    = 2'd1;
    bad = 0;
    for (int c = 1; c <= 501; c++) begin
      @(negedge clk);
      ifft_ready = 1'b0;
      #1;
      if (busy !== 1'b1 || remap_enable !== 1'b1) bad++;
    end
    chk("t6_running", 32'(bad), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_remap_enable", 32'(remap_enable), 32'd0);
    chk("t6_busy",         32'(busy), 32'd0);
    chk("t6_drop_cnt",     32'(drop_cnt), 32'd0);
    chk("t6_err_timeout",  32'(err_timeout), 32'd0);
    chk("t6_wr_bank",      32'(wr_bank), 32'd0);
    ifft_ready = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (busy !== 1'b0) bad++;
    end
    ifft_ready = 1'b0;
    chk("t6_banks_empty", 32'(bad), 32'd0);

    // Short frame is still closed and read as a full-length RUN
    send_frame(8, 1'b1, "t6_short");
    idle();
    chk("t6_short_wr_bank", 32'(wr_bank), 32'd1);
    serve(2'd3, -1, nb, ne, nbad, bk);
    chk("t6_short_bank", 32'(bk), 32'd0);
    chk("t6_short_len",  32'(nb), 32'd1026);
    chk("t6_short_path", 32'(nbad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
